axis_frame_gen: RTL

- Single-clock AXI4-Stream frame source (transmitter) that drives the s_axis side of the team's stream FIFOs and width adapters.
- Accepts one frame command at a time: length in bytes, tid, tdest, bad-frame flag and seed.
- Emits a frame of incrementing byte pattern with correct tkeep/tlast, and tuser bad-frame marking on the last beat.
- Used as traffic source for FIFO/adapter bring-up and as a built-in test generator.

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_frame_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream frame source: FSM state encoding
// and the byte-enable mask helper used to build tkeep for a partial beat.
package axis_pkg;

  // Widest tkeep the mask helper can build; wider streams need a larger value.
  localparam int MAX_KEEP_WIDTH = 128;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } frame_state_t;

  // Low min(count, keep_width) bits set, all others clear.
  function automatic logic [MAX_KEEP_WIDTH-1:0] keep_from_count(input int count,
                                                                input int keep_width);
    logic [MAX_KEEP_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
      mask[i] = (i < count) && (i < keep_width);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame source. Takes one command at a time and emits a frame of
// incrementing bytes starting at the command seed, with tkeep/tlast derived
// from the remaining byte count and an optional bad-frame marker in tuser on
// the last beat.
//
// Handshake rule used on both the command port and m_axis: a transfer happens
// on a rising clock edge where valid and ready are both high; the source keeps
// its payload stable from the cycle valid rises until that transfer.
module axis_frame_gen
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  input  logic                  cmd_bad,
  input  logic [7:0]            cmd_seed,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic                  status_len_error,
  output logic [31:0]           status_frame_count
);

  // Without tkeep the stream carries a single byte per beat in lane 0.
  localparam int BEAT_BYTES = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 1;
  localparam logic [LEN_WIDTH-1:0] BEAT_LEN  = LEN_WIDTH'(BEAT_BYTES);
  localparam logic [7:0]           BEAT_STEP = 8'(BEAT_BYTES);
  localparam logic [USER_WIDTH-1:0] USER_BAD = USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK;

  if ((KEEP_WIDTH * 8) != DATA_WIDTH) begin : g_keep_width_check
    $error("axis_frame_gen: DATA_WIDTH/KEEP_WIDTH must equal 8");
  end
  if (KEEP_WIDTH > MAX_KEEP_WIDTH) begin : g_keep_max_check
    $error("axis_frame_gen: KEEP_WIDTH exceeds axis_pkg::MAX_KEEP_WIDTH");
  end

  frame_state_t state_q;
  frame_state_t state_d;
  logic         ready_en_q;

  // Remaining bytes and first-lane byte of the beat currently on the bus.
  logic [LEN_WIDTH-1:0] remaining_q;
  logic [7:0]           byte_q;
  logic                 bad_q;

  logic cmd_fire;
  logic cmd_start;
  logic cmd_zero;
  logic beat_fire;
  logic last_fire;

  // Description of the beat to be loaded into the output registers.
  logic [LEN_WIDTH-1:0]  src_rem;
  logic [7:0]            src_byte;
  logic                  src_bad;
  logic [KEEP_WIDTH-1:0] beat_keep;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;
  logic [USER_WIDTH-1:0] beat_user;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cmd_start = cmd_fire & (cmd_len != '0);
  assign cmd_zero  = cmd_fire & (cmd_len == '0);
  assign beat_fire = m_axis_tvalid & m_axis_tready;
  assign last_fire = beat_fire & m_axis_tlast;

  // FSM state register; ready_en_q holds cmd_ready low until the first clock after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // FSM next state: a non-empty command starts a frame, the last handshake ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_start) state_d = ST_SEND;
      ST_SEND: if (last_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: command port open only in IDLE, beats valid for all of SEND.
  always_comb begin
    cmd_ready     = (state_q == ST_IDLE) && ready_en_q;
    busy          = (state_q == ST_SEND);
    m_axis_tvalid = (state_q == ST_SEND);
  end

  // Next beat: first beat of a new command, or the successor of the current beat.
  always_comb begin
    src_rem  = cmd_len;
    src_byte = cmd_seed;
    src_bad  = cmd_bad;
    if (state_q == ST_SEND) begin
      // Only consumed when the current beat is not last, so remaining_q > BEAT_LEN.
      src_rem  = remaining_q - BEAT_LEN;
      src_byte = byte_q + BEAT_STEP;
      src_bad  = bad_q;
    end
    beat_keep = KEEP_WIDTH'(keep_from_count(32'(src_rem), BEAT_BYTES));
    beat_data = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      beat_data[8*k +: 8] = beat_keep[k] ? (src_byte + 8'(k)) : 8'h00;
    end
    beat_last = (src_rem <= BEAT_LEN);
    beat_user = (beat_last && src_bad) ? USER_BAD : '0;
  end

  // Registered beat outputs: load on accept or on a non-last handshake, clear after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q  <= '0;
      byte_q       <= '0;
      bad_q        <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tid   <= '0;
      m_axis_tdest <= '0;
      m_axis_tuser <= '0;
    end else if (cmd_start || (beat_fire && !m_axis_tlast)) begin
      remaining_q  <= src_rem;
      byte_q       <= src_byte;
      m_axis_tdata <= beat_data;
      m_axis_tkeep <= beat_keep;
      m_axis_tlast <= beat_last;
      m_axis_tuser <= beat_user;
      if (cmd_start) begin
        bad_q        <= cmd_bad;
        m_axis_tid   <= cmd_id;
        m_axis_tdest <= cmd_dest;
      end
    end else if (last_fire) begin
      remaining_q  <= '0;
      bad_q        <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tid   <= '0;
      m_axis_tdest <= '0;
      m_axis_tuser <= '0;
    end
  end

  // Status: zero-length accept pulse and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_len_error   <= 1'b0;
      status_frame_count <= '0;
    end else begin
      status_len_error <= cmd_zero;
      if (last_fire) status_frame_count <= status_frame_count + 32'd1;
    end
  end

endmodule
